bus_addr_decode: RTL and testbench

//  Front end of the memory/IO slaves on the 8088-style multiplexed bus. Demultiplexes AD[7:0] with ALE

---
 rtl/bus_pkg.sv | 23 ++
 rtl/bus_addr_decode_addr_latch.sv | 31 +++
 rtl/bus_addr_decode.sv | 142 ++++++++++++++
 tb/tb_bus_addr_decode.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and address-field constants for the multiplexed bus front end.
package bus_pkg;

    typedef enum logic [1:0] {
        S_T1 = 2'd0,
        S_T2 = 2'd1,
        S_T3 = 2'd2,
        S_T4 = 2'd3
    } bus_state_t;

    localparam int MEM_BANK_MSB = 19;
    localparam int MEM_BANK_LSB = 18;
    localparam int IO_PORT_MSB  = 7;
    localparam int IO_PORT_LSB  = 6;

    // Address bits that must be zero for an IO cycle to hit a mapped port.
    localparam logic [19:0] IO_HI_ZERO = 20'hFFF00;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/bus_addr_decode_addr_latch.sv
// Address demultiplexer: flop-based 20-bit latch that is transparent while
// enabled, plus capture of the memory/IO qualifier at the same edge.
module addr_latch (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        i_le,
    input  logic [19:0] i_addr,
    input  logic        i_iom,
    output logic [19:0] o_addr,
    output logic        o_iom_q
);

    logic [19:0] r_addr;
    logic        r_iom_q;

    // Capture address and IOM at the end of an accepted ALE cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_addr  <= '0;
            r_iom_q <= 1'b0;
        end else if (i_le) begin
            r_addr  <= i_addr;
            r_iom_q <= i_iom;
        end
    end

    // Pass-through during the enable cycle gives same-cycle address to slaves.
    assign o_addr  = i_le ? i_addr : r_addr;
    assign o_iom_q = r_iom_q;

endmodule

// File: rtl/bus_addr_decode.sv
// Bus front end: address demux, one-hot chip selects held for the whole
// bus cycle, T-state tracking with stall timeout, and cycle/error counters.
//
//  state | meaning
//  S_T1  | idle / address phase, waiting for ALE
//  S_T2  | waiting for RD or WR strobe, timeout running
//  S_T3  | data transfer
//  S_T4  | cycle completion, counted
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter logic MEM_IOM = 1'b1,
    parameter int   TIMEOUT = 15,
    parameter int   CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [7:0]       AD,
    input  logic [11:0]      A_HI,
    input  logic             ALE,
    input  logic             IOM,
    input  logic             RD,
    input  logic             WR,
    output logic [19:0]      Address,
    output logic [3:0]       CS_MEM,
    output logic [3:0]       CS_IO,
    output logic             BUS_ERR,
    output logic [CNT_W-1:0] BUS_CYCLES,
    output logic [7:0]       ERR_CNT
);

    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    bus_state_t       r_state;
    bus_state_t       w_state_nxt;
    logic [TMO_W-1:0] r_tmo;
    logic [TMO_W-1:0] w_tmo_nxt;
    logic             w_tmo_hit;
    logic             r_err_q;
    logic [CNT_W-1:0] r_cycles;
    logic [7:0]       r_err_cnt;

    logic        w_le;
    logic        w_stray;
    logic        w_unmapped;
    logic        w_iom_q;
    logic        w_iom_eff;
    logic        w_is_mem;
    logic        w_io_hi_ok;
    logic        w_cs_en;
    logic        w_bus_err;

    // ALE only opens the latch at the start of a cycle; elsewhere it is an error.
    assign w_le    = ALE && (r_state == S_T1);
    assign w_stray = ALE && (r_state != S_T1);

    addr_latch u_latch (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_le    (w_le),
        .i_addr  ({A_HI, AD}),
        .i_iom   (IOM),
        .o_addr  (Address),
        .o_iom_q (w_iom_q)
    );

    // Live IOM is used during T1 so CS appears together with ALE.
    assign w_iom_eff  = (r_state == S_T1) ? IOM : w_iom_q;
    assign w_is_mem   = (w_iom_eff == MEM_IOM);
    assign w_io_hi_ok = ((Address & IO_HI_ZERO) == '0);
    assign w_cs_en    = !RESET && (w_le || (r_state != S_T1));
    assign w_unmapped = w_le && !w_is_mem && !w_io_hi_ok;

    // One-hot chip-select decode, at most one bit across both vectors.
    always_comb begin
        CS_MEM = '0;
        CS_IO  = '0;
        if (w_cs_en) begin
            if (w_is_mem)
                CS_MEM = onehot4(Address[MEM_BANK_MSB:MEM_BANK_LSB]);
            else if (w_io_hi_ok)
                CS_IO = onehot4(Address[IO_PORT_MSB:IO_PORT_LSB]);
        end
    end

    // T-state sequencing and stall timeout; RD and WR both lead to T3, so a
    // simultaneous RD/WR simply takes the read path.
    always_comb begin
        w_state_nxt = r_state;
        w_tmo_nxt   = r_tmo;
        w_tmo_hit   = 1'b0;
        case (r_state)
            S_T1: begin
                if (ALE) begin
                    w_state_nxt = S_T2;
                    w_tmo_nxt   = '0;
                end
            end
            S_T2: begin
                if (!RD || !WR) begin
                    w_state_nxt = S_T3;
                end else if (r_tmo == TMO_LAST) begin
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = S_T1;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            S_T3:    w_state_nxt = S_T4;
            S_T4:    w_state_nxt = S_T1;
            default: w_state_nxt = S_T1;
        endcase
    end

    // Timeout fires in the stalled T2 cycle itself; latched causes fire a cycle later.
    assign w_bus_err = r_err_q || w_tmo_hit;

    // State, timeout counter, error pulse register and saturating counters.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= S_T1;
            r_tmo     <= '0;
            r_err_q   <= 1'b0;
            r_cycles  <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmo   <= w_tmo_nxt;
            r_err_q <= w_unmapped || w_stray;
            if (r_state == S_T4 && r_cycles != '1)
                r_cycles <= r_cycles + CNT_W'(1);
            if (w_bus_err && r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign BUS_ERR    = w_bus_err;
    assign BUS_CYCLES = r_cycles;
    assign ERR_CNT    = r_err_cnt;

endmodule

// File: tb/tb_bus_addr_decode.sv
// Self-checking bench for bus_addr_decode: directed and randomized bus cycles
// against a transaction-level reference model.
module tb_bus_addr_decode;

    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic             CLK;
    logic             RESET;
    logic [7:0]       AD;
    logic [11:0]      A_HI;
    logic             ALE;
    logic             IOM;
    logic             RD;
    logic             WR;
    logic [19:0]      Address;
    logic [3:0]       CS_MEM;
    logic [3:0]       CS_IO;
    logic             BUS_ERR;
    logic [CNT_W-1:0] BUS_CYCLES;
    logic [7:0]       ERR_CNT;

    int total = 0;
    int bad   = 0;
    int exp_cycles = 0;
    int exp_errs   = 0;

    bus_addr_decode #(.MEM_IOM(1'b1), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .AD         (AD),
        .A_HI       (A_HI),
        .ALE        (ALE),
        .IOM        (IOM),
        .RD         (RD),
        .WR         (WR),
        .Address    (Address),
        .CS_MEM     (CS_MEM),
        .CS_IO      (CS_IO),
        .BUS_ERR    (BUS_ERR),
        .BUS_CYCLES (BUS_CYCLES),
        .ERR_CNT    (ERR_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Runs one complete bus cycle and checks every T-state against the model.
    task automatic bus_cycle(input logic [19:0] addr, input logic iom, input logic rd_lo,
                             input logic wr_lo, input int waits, input bit stray);
        logic [3:0] ecm;
        logic [3:0] eci;
        bit unmapped;
        bit strobe;
        bit exp_err;
        int n_t2;
        ecm = '0;
        eci = '0;
        if (iom) ecm = 4'(1 << (addr / 262144));
        else if (addr < 256) eci = 4'(1 << ((addr / 64) % 4));
        unmapped = !iom && (addr >= 256);
        strobe   = rd_lo || wr_lo;
        n_t2     = strobe ? waits + 1 : TIMEOUT;

        @(negedge CLK);
        ALE = 1'b1; {A_HI, AD} = addr; IOM = iom; RD = 1'b1; WR = 1'b1;
        #2;
        total++; if (Address !== addr) begin bad++; $display("FAIL t1_addr: got %h exp %h", Address, addr); end
        total++; if (CS_MEM !== ecm || CS_IO !== eci) begin bad++; $display("FAIL t1_cs: got %b/%b exp %b/%b", CS_MEM, CS_IO, ecm, eci); end
        total++; if (BUS_ERR !== 1'b0) begin bad++; $display("FAIL t1_err: got %b exp 0", BUS_ERR); end

        for (int k = 1; k <= n_t2; k++) begin
            @(negedge CLK);
            ALE = 1'b0; A_HI = 12'($urandom); AD = 8'($urandom); IOM = 1'($urandom);
            RD = !(strobe && k == n_t2 && rd_lo);
            WR = !(strobe && k == n_t2 && wr_lo);
            #2;
            exp_err = (k == 1 && unmapped) || (!strobe && k == n_t2);
            total++; if (Address !== addr) begin bad++; $display("FAIL t2_addr: got %h exp %h", Address, addr); end
            total++; if (CS_MEM !== ecm || CS_IO !== eci) begin bad++; $display("FAIL t2_cs: got %b/%b exp %b/%b", CS_MEM, CS_IO, ecm, eci); end
            total++; if (BUS_ERR !== exp_err) begin bad++; $display("FAIL t2_err k=%0d: got %b exp %b", k, BUS_ERR, exp_err); end
            if (exp_err && exp_errs < 255) exp_errs++;
        end

        if (strobe) begin
            @(negedge CLK);
            RD = 1'b1; WR = 1'b1; ALE = stray;
            if (stray) begin A_HI = ~addr[19:8]; AD = ~addr[7:0]; end
            #2;
            total++; if (Address !== addr) begin bad++; $display("FAIL t3_addr: got %h exp %h", Address, addr); end
            total++; if (CS_MEM !== ecm || CS_IO !== eci) begin bad++; $display("FAIL t3_cs: got %b/%b exp %b/%b", CS_MEM, CS_IO, ecm, eci); end
            total++; if (BUS_ERR !== 1'b0) begin bad++; $display("FAIL t3_err: got %b exp 0", BUS_ERR); end

            @(negedge CLK);
            ALE = 1'b0;
            #2;
            total++; if (Address !== addr) begin bad++; $display("FAIL t4_addr: got %h exp %h", Address, addr); end
            total++; if (CS_MEM !== ecm || CS_IO !== eci) begin bad++; $display("FAIL t4_cs: got %b/%b exp %b/%b", CS_MEM, CS_IO, ecm, eci); end
            total++; if (BUS_ERR !== stray) begin bad++; $display("FAIL t4_err: got %b exp %b", BUS_ERR, stray); end
            if (stray && exp_errs < 255) exp_errs++;
            if (exp_cycles < CNT_MAX) exp_cycles++;
        end

        @(negedge CLK);
        RD = 1'b1; WR = 1'b1; ALE = 1'b0;
        #2;
        total++; if (CS_MEM !== 4'b0 || CS_IO !== 4'b0) begin bad++; $display("FAIL idle_cs: got %b/%b exp 0/0", CS_MEM, CS_IO); end
        total++; if (BUS_ERR !== 1'b0) begin bad++; $display("FAIL idle_err: got %b exp 0", BUS_ERR); end
        total++; if (BUS_CYCLES !== CNT_W'(exp_cycles)) begin bad++; $display("FAIL bus_cycles: got %0d exp %0d", BUS_CYCLES, exp_cycles); end
        total++; if (ERR_CNT !== 8'(exp_errs)) begin bad++; $display("FAIL err_cnt: got %0d exp %0d", ERR_CNT, exp_errs); end
    endtask

    task automatic test_reset;
        RESET = 1'b1; ALE = 1'b0; AD = 8'h5A; A_HI = 12'hA5A; IOM = 1'b1; RD = 1'b1; WR = 1'b1;
        repeat (2) @(negedge CLK);
        #2;
        total++; if (Address !== 20'h0) begin bad++; $display("FAIL rst_addr: got %h exp 0", Address); end
        total++; if (CS_MEM !== 4'b0 || CS_IO !== 4'b0) begin bad++; $display("FAIL rst_cs: got %b/%b exp 0/0", CS_MEM, CS_IO); end
        total++; if (BUS_ERR !== 1'b0) begin bad++; $display("FAIL rst_err: got %b exp 0", BUS_ERR); end
        total++; if (BUS_CYCLES !== '0 || ERR_CNT !== 8'h0) begin bad++; $display("FAIL rst_cnt: got %0d/%0d exp 0/0", BUS_CYCLES, ERR_CNT); end
        @(negedge CLK);
        RESET = 1'b0;
        exp_cycles = 0;
        exp_errs   = 0;
    endtask

    task automatic test_mem_read;
        bus_cycle(20'h8A034, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        bus_cycle(20'h3FFFF, 1'b1, 1'b1, 1'b0, 3, 1'b0);
    endtask

    task automatic test_io_write;
        bus_cycle(20'h000C0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        bus_cycle(20'h00040, 1'b0, 1'b0, 1'b1, TIMEOUT - 1, 1'b0);
    endtask

    task automatic test_timeout;
        bus_cycle(20'hC1234, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_unmapped_stray;
        bus_cycle(20'h01040, 1'b0, 1'b1, 1'b0, 1, 1'b1);
    endtask

    task automatic test_random;
        logic [19:0] a;
        int sel;
        for (int n = 0; n < 20; n++) begin
            a = 20'($urandom);
            if ($urandom_range(0, 1) == 1) a = a % 256;
            sel = $urandom_range(0, 7);
            bus_cycle(a, 1'($urandom), sel == 0 ? 1'b0 : 1'($urandom),
                      sel == 0 ? 1'b0 : 1'($urandom), $urandom_range(0, TIMEOUT - 1),
                      1'($urandom));
        end
    endtask

    task automatic test_async_reset;
        @(negedge CLK);
        ALE = 1'b1; {A_HI, AD} = 20'h4ABCD; IOM = 1'b1; RD = 1'b1; WR = 1'b1;
        @(negedge CLK);
        ALE = 1'b0; RD = 1'b0;
        @(negedge CLK);
        RD = 1'b1;
        #2;
        total++; if (CS_MEM !== 4'b0010) begin bad++; $display("FAIL ar_t3_cs: got %b exp 0010", CS_MEM); end
        RESET = 1'b1;
        #1;
        total++; if (CS_MEM !== 4'b0 || CS_IO !== 4'b0) begin bad++; $display("FAIL ar_cs: got %b/%b exp 0/0", CS_MEM, CS_IO); end
        total++; if (BUS_CYCLES !== '0 || ERR_CNT !== 8'h0) begin bad++; $display("FAIL ar_cnt: got %0d/%0d exp 0/0", BUS_CYCLES, ERR_CNT); end
        @(negedge CLK);
        RESET = 1'b0;
        exp_cycles = 0;
        exp_errs   = 0;
        bus_cycle(20'h20010, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_saturation;
        for (int n = 0; n < 17; n++)
            bus_cycle(20'($urandom), 1'b1, 1'b1, 1'b1, $urandom_range(0, 2), 1'b0);
        total++; if (BUS_CYCLES !== 4'hF) begin bad++; $display("FAIL sat: got %h exp F", BUS_CYCLES); end
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_io_write();
        test_timeout();
        test_unmapped_stray();
        test_random();
        test_async_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish exp finish");
        $fatal(1);
    end

endmodule
